// File: rtl/ordena_n_serial.sv
// Streaming sort engine: loads an N-word frame, sorts it with an odd-even
// transposition network (one phase per cycle), then drains it over valid/ready.
module ordena_n_serial #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         cresc_ou_decres,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         ocupado
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {CARGA = 2'd0, ORDENA = 2'd1, ENVIA = 2'd2} state_t;

  state_t        r_state, w_state_nx;
  logic [W-1:0]  r_mem [N];
  logic [W-1:0]  w_net [N];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [CW-1:0] r_phase;
  logic          r_arm;
  logic          r_ena;
  logic          r_asc;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic          r_out_last;
  logic          w_accept;
  logic          w_xfer;

  function automatic logic need_swap(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic asc);
    return asc ? (a > b) : (a < b);
  endfunction

  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_out_valid && out_ready;
  assign w_cnt_nx = r_cnt + 1'b1;

  // Compare-swap network: even phases pair (0,1),(2,3)..; odd phases (1,2),(3,4)..
  always_comb begin
    w_net = r_mem;
    for (int i = 0; i < N - 1; i++) begin
      if (((i % 2) == 1) == r_phase[0]) begin
        if (need_swap(r_mem[i], r_mem[i+1], r_asc)) begin
          w_net[i]   = r_mem[i+1];
          w_net[i+1] = r_mem[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= CARGA;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      CARGA:   if (w_accept && r_cnt == LAST) w_state_nx = r_ena ? ORDENA : ENVIA;
      ORDENA:  if (r_phase == LAST) w_state_nx = ENVIA;
      ENVIA:   if (w_xfer && r_out_last) w_state_nx = CARGA;
      default: w_state_nx = CARGA;
    endcase
  end

  always_comb begin
    in_ready = (r_state == CARGA) && r_arm;
    ocupado  = (r_state == ORDENA) || (r_state == ENVIA);
  end

  // Storage: no reset, contents are don't-care until a frame is loaded
  always_ff @(posedge clk) begin
    if (r_state == ORDENA) r_mem <= w_net;
    else if (w_accept)     r_mem[r_cnt[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_arm       <= 1'b0;
      r_cnt       <= '0;
      r_phase     <= '0;
      r_ena       <= 1'b0;
      r_asc       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_arm <= 1'b1;
      case (r_state)
        CARGA: begin
          if (w_accept) begin
            if (r_cnt == '0) begin
              r_ena <= ena;
              r_asc <= cresc_ou_decres;
            end
            if (r_cnt == LAST) begin
              r_cnt <= '0;
              if (!r_ena) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_mem[0];
                r_out_last  <= 1'b0;
              end
            end else begin
              r_cnt <= w_cnt_nx;
            end
          end
        end
        ORDENA: begin
          if (r_phase == LAST) begin
            // First output must reflect the final phase being written this edge
            r_phase     <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_net[0];
            r_out_last  <= 1'b0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        ENVIA: begin
          if (w_xfer) begin
            if (r_out_last) begin
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_out_last  <= 1'b0;
            end else begin
              r_cnt      <= w_cnt_nx;
              r_out_data <= r_mem[w_cnt_nx[AW-1:0]];
              r_out_last <= (w_cnt_nx == LAST);
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: doc/ordena_n_serial.md
Name: ordena_n_serial

Overview:
- Streaming sort engine built on the 2-number compare-swap rule.
- Accepts a frame of N words over a valid/ready input stream and sorts it in place with an odd-even transposition network, one phase per cycle.
- Emits the frame over a valid/ready output stream with a last marker.
- Sits between a producer of unordered samples and a consumer that requires ordered samples.

Parameters:
- N, 8, words per frame; legal range 2..64.
- W, 8, data word width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  1 = sort the frame; 0 = pass the frame through in arrival order. Sampled with the first word of a frame.
- cresc_ou_decres  input  1  1 = ascending (smallest first); 0 = descending. Sampled with the first word of a frame.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  W  input word.
- in_ready  output  1  block accepts a word this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  W  output word.
- out_last  output  1  marks the final (N-th) word of a frame; qualified by out_valid.
- out_ready  input  1  consumer accepts a word this cycle.
- ocupado  output  1  high in ORDENA and ENVIA states.

Behaviour:
- Reset (rst=1 at an edge):
  - state=CARGA; word counter=0; storage contents don't-care.
  - While rst is high: in_ready=0, out_valid=0, out_data=0, out_last=0, ocupado=0.
  - After the first edge with rst=0: in_ready=1.
  - Reset mid-frame discards all stored words and any partially sent frame.
- Storage: register array r[0..N-1], W bits each. Counter widths are $clog2(N)+1.
- CARGA:
  - in_ready=1.
  - Accept rule: in_valid & in_ready writes in_data to r[cnt] and increments cnt.
  - On accept with cnt==0: latch ena and cresc_ou_decres into mode registers. Later changes on these inputs have no effect on the current frame.
  - On accept with cnt==N-1: cnt<=0. Next state is ORDENA if latched ena=1, else ENVIA.
- ORDENA:
  - in_ready=0. Runs exactly N cycles, with phase counter p=0..N-1.
  - Even p compares pairs (0,1),(2,3),...; odd p compares pairs (1,2),(3,4),...
  - All pairs in a phase update in the same cycle.
  - Ascending mode: r[i]<=min, r[i+1]<=max. Descending mode: r[i]<=max, r[i+1]<=min.
  - Comparison is unsigned. Equal values are left unswapped.
  - After phase N-1: next state ENVIA, cnt=0.
- ENVIA:
  - in_ready=0; out_valid=1; out_data=r[cnt]; out_last=(cnt==N-1).
  - Transfer rule: out_valid & out_ready increments cnt.
  - While stalled (out_ready=0), out_data and out_last hold stable.
  - Transfer with out_last=1: next state CARGA with cnt=0. out_valid=0 and in_ready=1 in the following cycle.
  - No overlap between frames: input is never accepted while a frame is pending.
- Latency, with last input accepted at edge T:
  - Sort mode: out_valid first high in the cycle after edge T+N.
  - Pass-through mode: out_valid first high in the cycle after edge T.
  - With out_ready held at 1, the frame drains in N consecutive cycles.
- in_valid=0 in the middle of loading: block waits indefinitely; no timeout.
- out_valid and out_data are registered outputs. in_ready and ocupado are decoded from the registered state only.

Test Plan:
- Reset then ena=1, cresc=1, input 5,3,8,1,9,2,7,4 with out_ready=1 -> out_valid high 8 cycles after the last accept; output 1,2,3,4,5,7,8,9; out_last only on 9; in_ready=1 the cycle after.
- ena=1, cresc=0, input 0,255,16,16,1,128,3,3 -> output 255,128,16,16,3,3,1,0.
- ena=0, cresc=1, input 5,3,8,1,9,2,7,4 -> out_valid one cycle after the last accept; output in arrival order 5,3,8,1,9,2,7,4.
- Sorted frame with out_ready toggling 1,0,0,1,... -> each word held stable during stalls; all 8 words delivered once each, in order; in_valid asserted during ENVIA is ignored (in_ready=0).
- Mode flip: cresc=1 on the first word, switched to 0 after the third word -> frame still sorted ascending; the next frame uses the new value.
- rst asserted in ORDENA at phase 3, then a fresh frame 7,6,5,4,3,2,1,0 (ascending) -> outputs zero during reset; next frame out 0..7; no residue from the aborted frame.
